conv_row_mac: RTL

- Sequential 3x3 convolution front end that produces the three row partial sums consumed by the saturation adder (in0/in1/in2).
- Accepts one pixel/weight pair per handshake in raster order: row 0 taps 0..2, then row 1, then row 2.
- Accumulates each row's signed products and presents all three sums together behind a valid/ready output stage.
- Sits between the window fetch logic and the saturation adder.

---
 rtl/conv_row_mac_if.sv | 26 ++
 rtl/conv_row_mac.sv | 131 +++++++++++++
 2 files changed

// File: rtl/conv_row_mac_if.sv
// Pixel/weight input and row-sum output handshake bundle for conv_row_mac.
// The master side feeds pairs and accepts windows; the slave side is the MAC block.
interface conv_row_mac_if #(
    parameter int DATA_BITS = 9,
    parameter int PSUM_BITS = 2*DATA_BITS+2
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [DATA_BITS-1:0] pixel;
    logic signed [DATA_BITS-1:0] weight;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [PSUM_BITS-1:0] psum0;
    logic signed [PSUM_BITS-1:0] psum1;
    logic signed [PSUM_BITS-1:0] psum2;

    modport master (
        output in_valid, pixel, weight, out_ready,
        input  in_ready, out_valid, psum0, psum1, psum2
    );

    modport slave (
        input  in_valid, pixel, weight, out_ready,
        output in_ready, out_valid, psum0, psum1, psum2
    );
endinterface

// File: rtl/conv_row_mac.sv
// Sequential 3x3 convolution front end: accumulates nine pixel*weight products
// into three row partial sums and presents them together behind valid/ready.
module conv_row_mac #(
    parameter int DATA_BITS = 9,
    parameter int PSUM_BITS = 2*DATA_BITS+2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    conv_row_mac_if.slave     bus
);
    localparam int PROD_BITS = 2*DATA_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [3:0]                  count_q, count_d;
    logic signed [PSUM_BITS-1:0] acc0_q, acc0_d;
    logic signed [PSUM_BITS-1:0] acc1_q, acc1_d;
    logic signed [PSUM_BITS-1:0] acc2_q, acc2_d;
    logic                        out_valid_q, out_valid_d;

    logic signed [PROD_BITS-1:0] prod_s;
    logic signed [PSUM_BITS-1:0] prod_ext_s;
    logic                        accept_s;
    logic [1:0]                  row_s;

    assign prod_s     = bus.pixel * bus.weight;
    assign prod_ext_s = {{(PSUM_BITS-PROD_BITS){prod_s[PROD_BITS-1]}}, prod_s};

    // in_ready is gated by rst_n so it reads low for the whole reset interval
    assign bus.in_ready  = rst_n & (state_q != OUT);
    assign accept_s      = bus.in_valid & bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.psum0     = acc0_q;
    assign bus.psum1     = acc1_q;
    assign bus.psum2     = acc2_q;

    // Row index of the current tap: taps 0..2 row 0, 3..5 row 1, 6..8 row 2
    always_comb begin
        row_s = 2'd2;
        case (count_q)
            4'd0, 4'd1, 4'd2: row_s = 2'd0;
            4'd3, 4'd4, 4'd5: row_s = 2'd1;
            default:          row_s = 2'd2;
        endcase
    end

    // Next-state, tap counter and accumulator update; clr overrides everything
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc0_d  = acc0_q;
        acc1_d  = acc1_q;
        acc2_d  = acc2_q;
        if (clr) begin
            state_d = IDLE;
            count_d = 4'd0;
            acc0_d  = {PSUM_BITS{1'b0}};
            acc1_d  = {PSUM_BITS{1'b0}};
            acc2_d  = {PSUM_BITS{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        acc0_d  = prod_ext_s;
                        acc1_d  = {PSUM_BITS{1'b0}};
                        acc2_d  = {PSUM_BITS{1'b0}};
                        count_d = 4'd1;
                        state_d = ACC;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACC: begin
                    if (accept_s) begin
                        case (row_s)
                            2'd0:    acc0_d = acc0_q + prod_ext_s;
                            2'd1:    acc1_d = acc1_q + prod_ext_s;
                            default: acc2_d = acc2_q + prod_ext_s;
                        endcase
                        if (count_q == 4'd8) begin
                            count_d = 4'd0;
                            state_d = OUT;
                        end else begin
                            count_d = count_q + 4'd1;
                        end
                    end else begin
                        state_d = ACC;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = OUT;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = 4'd0;
                end
            endcase
        end
    end

    assign out_valid_d = (state_d == OUT);

    // State, counter, accumulator and output-valid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= 4'd0;
            acc0_q      <= {PSUM_BITS{1'b0}};
            acc1_q      <= {PSUM_BITS{1'b0}};
            acc2_q      <= {PSUM_BITS{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc0_q      <= acc0_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule
